// File: rtl/led_pkg.sv
// Shared types and constants for the LED step controller: debounce state
// encoding, key indices, speed width and the step-period helper.
package led_pkg;

    // Debounce FSM states, one FSM per push-button.
    typedef enum logic [1:0] {
        DB_RELEASED     = 2'd0,
        DB_PRESS_WAIT   = 2'd1,
        DB_PRESSED      = 2'd2,
        DB_RELEASE_WAIT = 2'd3
    } db_state_t;

    // Key positions on the key_n bus.
    localparam int NUM_KEYS  = 3;
    localparam int KEY_PAUSE = 0;
    localparam int KEY_DIR   = 1;
    localparam int KEY_SPEED = 2;

    // Speed index width and prescaler width.
    localparam int SPEED_W = 2;
    localparam int PRESC_W = 32;

    // Step period for a given speed index: the base period halved per speed
    // level, truncating. With the base period >= 8 this never reaches zero.
    function automatic logic [PRESC_W-1:0] step_period(
        input logic [PRESC_W-1:0] base,
        input logic [SPEED_W-1:0] spd
    );
        return base >> spd;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button conditioner: 2-flop synchronizer, four-state debounce FSM
// with a stability window counter, and a single-cycle press pulse.
// The press pulse fires once per accepted press; releases are silent.
module key_debounce
    import led_pkg::*;
#(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic nrst,
    input  logic key_n,
    output logic press
);

    // The sample that moves the FSM into a wait state counts as the first
    // stable sample, so the wait state needs DB_CYCLES-1 more of them.
    localparam int                CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 2);

    logic [1:0]       sync_d,  sync_q;
    db_state_t        state_d, state_q;
    logic [CNT_W-1:0] cnt_d,   cnt_q;
    logic             press_d, press_q;
    logic             key_s;

    assign key_s = sync_q[1];
    assign press = press_q;

    // Next-state logic for the synchronizer, FSM, window counter and pulse.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        sync_d  = {sync_q[0], key_n};
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;

        case (state_q)
            DB_RELEASED: begin
                if (!key_s) state_d = DB_PRESS_WAIT;
            end
            DB_PRESS_WAIT: begin
                if (key_s) begin
                    state_d = DB_RELEASED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_PRESSED;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DB_PRESSED: begin
                if (key_s) state_d = DB_RELEASE_WAIT;
            end
            DB_RELEASE_WAIT: begin
                if (!key_s) begin
                    state_d = DB_PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_RELEASED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = DB_RELEASED;
        endcase

        // Any state change restarts the stability window.
        if (state_d != state_q) cnt_d = '0;
    end

    // Synchronizer, FSM state, window counter and press pulse registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q  <= 2'b11;
            state_q <= DB_RELEASED;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

endmodule

// File: rtl/led_step_ctrl.sv
// LED pattern step controller: three debounced keys control run/pause,
// direction and speed; a prescaler emits one step pulse per period.
// TICK_CYCLES must be >= 8 and DB_CYCLES >= 2.
module led_step_ctrl
    import led_pkg::*;
#(
    parameter int TICK_CYCLES = 50000000,
    parameter int DB_CYCLES   = 1000000
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [2:0]         key_n,
    output logic               step,
    output logic               dir,
    output logic               running,
    output logic [SPEED_W-1:0] speed
);

    localparam logic [PRESC_W-1:0] BASE_PERIOD = PRESC_W'(TICK_CYCLES);

    logic [NUM_KEYS-1:0] press;

    logic [PRESC_W-1:0]  presc_d,   presc_q;
    logic                step_d,    step_q;
    logic                dir_d,     dir_q;
    logic                running_d, running_q;
    logic [SPEED_W-1:0]  speed_d,   speed_q;

    logic [PRESC_W-1:0]  period;
    logic [PRESC_W-1:0]  period_last;
    logic                term_cnt;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_key_debounce (
            .clk   (clk),
            .nrst  (nrst),
            .key_n (key_n[i]),
            .press (press[i])
        );
    end

    assign step    = step_q;
    assign dir     = dir_q;
    assign running = running_q;
    assign speed   = speed_q;

    // Control toggles, speed cycling and prescaler/step next-state.
    always_comb begin
        period      = step_period(BASE_PERIOD, speed_q);
        period_last = period - PRESC_W'(1);
        term_cnt    = (presc_q == period_last);

        running_d = running_q ^ press[KEY_PAUSE];
        dir_d     = dir_q ^ press[KEY_DIR];
        speed_d   = speed_q + SPEED_W'(press[KEY_SPEED]);
        presc_d   = presc_q;
        step_d    = 1'b0;

        if (press[KEY_SPEED]) begin
            // A speed change restarts the period and swallows any step due now.
            presc_d = '0;
        end else if (running_q) begin
            // A pause press still lets this cycle's step out: running_q is pre-edge.
            if (term_cnt) begin
                presc_d = '0;
                step_d  = 1'b1;
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end
    end

    // Prescaler and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            presc_q   <= '0;
            step_q    <= 1'b0;
            dir_q     <= 1'b0;
            running_q <= 1'b1;
            speed_q   <= '0;
        end else begin
            presc_q   <= presc_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            running_q <= running_d;
            speed_q   <= speed_d;
        end
    end

endmodule

// File: tb/tb_led_step_ctrl.sv
// Scoreboard bench for led_step_ctrl with TICK_CYCLES=16, DB_CYCLES=4.
// Stimulus pushes the expected cycle of every step pulse and every change of
// {dir, running, speed}; a monitor pops and compares as the DUT shows them.
// Cycle numbers count clock edges since the latest reset release.
module tb_led_step_ctrl;

    localparam int TICK = 16;
    localparam int DB   = 4;

    logic       clk   = 1'b0;
    logic       nrst  = 1'b0;
    logic [2:0] key_n = 3'b111;
    logic       step;
    logic       dir;
    logic       running;
    logic [1:0] speed;
    logic [3:0] ctrl;

    assign ctrl = {dir, running, speed};

    always #5 clk = ~clk;

    led_step_ctrl #(
        .TICK_CYCLES (TICK),
        .DB_CYCLES   (DB)
    ) dut (
        .clk     (clk),
        .nrst    (nrst),
        .key_n   (key_n),
        .step    (step),
        .dir     (dir),
        .running (running),
        .speed   (speed)
    );

    typedef struct {
        int         at;
        logic [3:0] val;
    } ctrl_ev_t;

    int       cyc;
    int       step_exp[$];
    ctrl_ev_t ctrl_exp[$];
    ctrl_ev_t ev;
    logic [3:0] prev_ctrl;
    int       n_tests = 0;
    int       n_fail  = 0;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every step pulse and every control change must match the queue head.
    always @(negedge clk) begin
        if (!nrst) begin
            prev_ctrl <= ctrl;
        end else begin
            if (step === 1'b1) begin
                if (step_exp.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL step_unexpected: step at cycle %0d, none expected", cyc);
                end else begin
                    check("step_cycle", cyc, step_exp.pop_front());
                end
            end
            if (ctrl !== prev_ctrl) begin
                if (ctrl_exp.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL ctrl_unexpected: ctrl %b at cycle %0d, none expected", ctrl, cyc);
                end else begin
                    ev = ctrl_exp.pop_front();
                    check("ctrl_cycle", cyc, ev.at);
                    check("ctrl_value", ctrl, ev.val);
                end
            end
            prev_ctrl <= ctrl;
        end
    end

    task automatic go_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push_step(input int at);
        step_exp.push_back(at);
    endtask

    task automatic push_ctrl(input int at, input logic d, input logic r, input logic [1:0] s);
        ctrl_ev_t e;
        e.at  = at;
        e.val = {d, r, s};
        ctrl_exp.push_back(e);
    endtask

    // Drive key k low at cycle n for len cycles.
    task automatic press_key(input int k, input int n, input int len);
        go_to(n);
        key_n[k] = 1'b0;
        go_to(n + len);
        key_n[k] = 1'b1;
    endtask

    // Assert reset at the current negedge, apply keys, verify reset outputs, release.
    task automatic do_reset(input logic [2:0] keys);
        nrst  = 1'b0;
        key_n = keys;
        @(negedge clk);
        @(negedge clk);
        check("reset_step", step, 0);
        check("reset_ctrl", ctrl, 4'b0100);
        nrst = 1'b1;
    endtask

    task automatic end_scenario(input string name);
        check({name, "_steps_left"}, step_exp.size(), 0);
        check({name, "_ctrl_left"}, ctrl_exp.size(), 0);
        step_exp.delete();
        ctrl_exp.delete();
    endtask

    initial begin
        // Free-running after reset: steps every 16 cycles.
        do_reset(3'b111);
        for (int i = 1; i <= 4; i++) push_step(16 * i);
        go_to(72);
        check("free_run_ctrl", ctrl, 4'b0100);
        end_scenario("free_run");

        // Short press ignored; long press pauses at 43; resume at 67 from held count 11.
        do_reset(3'b111);
        push_step(16);
        push_step(32);
        press_key(0, 20, 3);
        go_to(30);
        check("short_press_running", running, 1);
        push_ctrl(43, 1'b0, 1'b0, 2'd0);
        press_key(0, 36, 10);
        go_to(55);
        check("paused_running", running, 0);
        push_ctrl(67, 1'b0, 1'b1, 2'd0);
        press_key(0, 60, 10);
        push_step(72);
        push_step(88);
        go_to(95);
        end_scenario("pause");

        // Bouncing speed key then held: one increment at 67, period becomes 8.
        do_reset(3'b111);
        foreach (step_exp[i]) step_exp.delete(i);
        push_step(16); push_step(32); push_step(48); push_step(64);
        push_step(75); push_step(83); push_step(91);
        push_ctrl(67, 1'b0, 1'b1, 2'd1);
        for (int b = 0; b < 5; b++) begin
            go_to(40 + 4 * b);
            key_n[2] = 1'b0;
            go_to(42 + 4 * b);
            key_n[2] = 1'b1;
        end
        go_to(60);
        key_n[2] = 1'b0;
        go_to(80);
        key_n[2] = 1'b1;
        go_to(92);
        end_scenario("bounce");

        // Four clean speed presses: speed 1,2,3,0 with periods 8,4,2,16.
        do_reset(3'b111);
        push_step(16); push_step(32); push_step(48); push_step(64);
        push_step(75); push_step(83); push_step(91);
        push_step(101); push_step(105); push_step(109); push_step(113);
        for (int t = 116; t <= 128; t += 2) push_step(t);
        push_step(145); push_step(161);
        push_ctrl(67,  1'b0, 1'b1, 2'd1);
        push_ctrl(97,  1'b0, 1'b1, 2'd2);
        push_ctrl(114, 1'b0, 1'b1, 2'd3);
        push_ctrl(129, 1'b0, 1'b1, 2'd0);
        press_key(2, 60, 6);
        press_key(2, 90, 6);
        press_key(2, 107, 6);
        press_key(2, 122, 6);
        go_to(165);
        end_scenario("speed_cycle");

        // Speed press lands on terminal count 48: step suppressed, next at 56.
        do_reset(3'b111);
        push_step(16); push_step(32); push_step(56); push_step(64);
        push_ctrl(48, 1'b0, 1'b1, 2'd1);
        press_key(2, 41, 6);
        go_to(48);
        check("tc_speed_step_suppressed", step, 0);
        go_to(70);
        end_scenario("speed_tc");

        // Dir and pause pressed together at terminal count 48: both toggle, step kept.
        do_reset(3'b111);
        push_step(16); push_step(32); push_step(48);
        push_ctrl(48, 1'b1, 1'b0, 2'd0);
        go_to(41);
        key_n[1:0] = 2'b00;
        go_to(47);
        key_n[1:0] = 2'b11;
        go_to(48);
        check("tc_pause_step_kept", step, 1);
        push_ctrl(67, 1'b1, 1'b1, 2'd0);
        push_step(83);
        press_key(0, 60, 6);
        go_to(90);
        end_scenario("dual_key");

        // Reset with speed key held in PRESSED at speed 2; key released during reset.
        do_reset(3'b111);
        push_step(16); push_step(35); push_step(43);
        push_ctrl(27, 1'b0, 1'b1, 2'd1);
        push_ctrl(47, 1'b0, 1'b1, 2'd2);
        press_key(2, 20, 6);
        go_to(40);
        key_n[2] = 1'b0;
        go_to(49);
        check("held_speed_before_reset", speed, 2);
        end_scenario("held_reset_pre");
        do_reset(3'b111);
        push_step(16); push_step(32); push_step(45); push_step(53);
        go_to(30);
        check("no_increment_after_reset", speed, 0);
        push_ctrl(37, 1'b0, 1'b1, 2'd1);
        press_key(2, 30, 6);
        go_to(58);
        end_scenario("held_reset_post");

        // Reset mid-debounce with the key held through release: full window again.
        do_reset(3'b111);
        go_to(10);
        key_n[2] = 1'b0;
        go_to(14);
        end_scenario("mid_db_pre");
        do_reset(3'b011);
        push_ctrl(7, 1'b0, 1'b1, 2'd1);
        push_step(15);
        push_step(23);
        go_to(6);
        check("mid_db_no_early_pulse", speed, 0);
        go_to(26);
        key_n[2] = 1'b1;
        go_to(30);
        end_scenario("mid_db_post");

        nrst = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/led_step_ctrl.md
LED_STEP_CTRL -- requirements
Module: led_step_ctrl

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 50000000; base step period in clk cycles (1 s at 50 MHz); must be >= 8.
REQ-002 SHALL have parameter DB_CYCLES, default 1000000; debounce stability window in clk cycles (20 ms at 50 MHz); must be >= 2.
REQ-003 SHALL have port clk  input  1  system clock, 50 MHz.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port key_n  input  3  raw push-buttons, asynchronous, active-low: [0] pause/run toggle, [1] direction toggle, [2] speed cycle.
REQ-006 SHALL have port step  output  1  one-cycle pulse that advances the downstream LED pattern stage by one position.
REQ-007 SHALL have port dir  output  1  pattern direction: 0 = toward MSB, 1 = toward LSB.
REQ-008 SHALL have port running  output  1  1 = stepping enabled, 0 = paused.
REQ-009 SHALL have port speed  output  2  speed index; 0 is slowest.

Function
REQ-010 Each key_n bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each key SHALL have a debounce FSM with states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-012 RELEASED SHALL go to PRESS_WAIT on synced 0; PRESS_WAIT SHALL return to RELEASED on synced 1.
REQ-013 PRESS_WAIT SHALL go to PRESSED after DB_CYCLES consecutive synced-0 cycles and emit a one-cycle press pulse on that transition.
REQ-014 PRESSED SHALL go to RELEASE_WAIT on synced 1; RELEASE_WAIT SHALL go to RELEASED after DB_CYCLES consecutive synced-1 cycles, or back to PRESSED on synced 0. A release SHALL NOT produce a pulse.
REQ-015 Each debounce window counter SHALL clear on every state change, and a held key SHALL produce exactly one press pulse.
REQ-016 A press pulse on key 0 SHALL toggle running, and a press pulse on key 1 SHALL toggle dir; both take effect on the next clk edge.
REQ-017 A press pulse on key 2 SHALL increment speed modulo 4 (3 -> 0) and clear the prescaler to 0 on the same edge.
REQ-018 The step period SHALL be P = TICK_CYCLES >> speed, i.e. TICK_CYCLES, /2, /4 or /8 with truncation.
REQ-019 While running = 1, the prescaler SHALL count 0..P-1 and wrap, and step SHALL be 1 for exactly the cycle after the prescaler reaches P-1 (one pulse per P cycles).
REQ-020 While running = 0, the prescaler SHALL hold its value and step SHALL stay 0; on resume, counting continues from the held value.
REQ-021 A speed press coinciding with terminal count SHALL suppress that step, and counting SHALL restart at 0 with the new P.
REQ-022 A pause press coinciding with terminal count SHALL still emit that step, and pausing SHALL apply from the next cycle.
REQ-023 Simultaneous press pulses on different keys SHALL all be applied on the same edge.
REQ-024 The prescaler SHALL be 32 bits wide, and the comparison SHALL never see P = 0.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 On nrst low, the block SHALL reset asynchronously to: step=0, dir=0, running=1, speed=0, prescaler=0, synchronizer flops=1, all debounce FSMs=RELEASED with window counters 0.
REQ-027 On nrst low mid-debounce or mid-period, the block SHALL discard all progress, so a key held through reset release must complete a full DB_CYCLES window before it pulses.
REQ-028 Deassertion of nrst SHALL be applied synchronously to clk by the top level, not by this block.

Structure
REQ-029 Package led_pkg SHALL hold the debounce state encoding, the key index constants (KEY_PAUSE=0, KEY_DIR=1, KEY_SPEED=2) and the speed width (2).
REQ-030 Sub-module key_debounce (synchronizer, FSM and window counter, parameter DB_CYCLES, output press pulse) SHALL be instantiated three times.
REQ-031 The prescaler and the control registers SHALL stay in led_step_ctrl.

Verification (TICK_CYCLES=16, DB_CYCLES=4)
REQ-032 Reset release with no keys pressed -> step pulses at cycles 16, 32, 48, ...; dir=0, running=1, speed=0.
REQ-033 key_n[0] low for 3 cycles only -> no pulse and running stays 1; low for 10 cycles -> running=0 within 7 cycles and step silent; a second 10-cycle press -> stepping resumes from the held count.
REQ-034 key_n[2] bouncing 1/0 every 2 cycles for 20 cycles, then held low -> exactly one speed increment; four clean presses -> speed 1, 2, 3, 0 with periods 8, 4, 2, 16.
REQ-035 Speed press pulse landing on the terminal-count cycle -> no step that cycle, and the next step comes 8 cycles later.
REQ-036 key_n[1] and key_n[0] pressed simultaneously -> dir and running toggle on the same edge.
REQ-037 nrst pulsed low while key_n[2] is held low in PRESSED with speed=2 -> speed=0, and no new increment until the key is released and pressed again.
